alsu_pipe: RTL

Next-generation parametrised arithmetic/logic/shift unit with a valid/ready input handshake, a registered result with a valid pulse, an iterative shift-add multiplier and variable-distance shift/rotate. It keeps the existing ALSU opcode map, reduction, bypass, INPUT_PRIORITY and FULL_ADDER semantics. It adds a clock-divided LED blinker for invalid commands. It sits between operand sources and display/consumer logic on the board.

---
 rtl/alsu_pkg.sv | 22 ++
 rtl/alsu_pipe_if.sv | 33 +++
 rtl/alsu_seq_mult.sv | 48 ++++
 rtl/alsu_pipe.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared opcode map, FSM encoding and priority constants for the ALSU pipe.
package alsu_pkg;
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;
    localparam logic [2:0] OP_INV6  = 3'd6;
    localparam logic [2:0] OP_INV7  = 3'd7;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam string PRI_A = "A";
    localparam string PRI_B = "B";

    // Reductions are only meaningful for the bitwise ops.
    function automatic logic is_invalid(logic [2:0] op, logic red_a, logic red_b);
        return (op == OP_INV6) || (op == OP_INV7) ||
               ((red_a || red_b) && (op != OP_AND) && (op != OP_XOR));
    endfunction
endpackage

// File: rtl/alsu_pipe_if.sv
// Command/result bundle between operand sources and the ALSU pipe.
interface alsu_pipe_if #(parameter int BITS = 3);
    localparam int SW = $clog2(2*BITS);

    logic                in_valid;
    logic                in_ready;
    logic [2:0]          opcode;
    logic [BITS-1:0]     A;
    logic [BITS-1:0]     B;
    logic                cin;
    logic                serial_in;
    logic                direction;
    logic [SW-1:0]       shamt;
    logic                red_op_A;
    logic                red_op_B;
    logic                bypass_A;
    logic                bypass_B;
    logic                out_valid;
    logic [2*BITS-1:0]   out;
    logic                err;
    logic [15:0]         leds;

    modport master (
        output in_valid, opcode, A, B, cin, serial_in, direction, shamt,
               red_op_A, red_op_B, bypass_A, bypass_B,
        input  in_ready, out_valid, out, err, leds
    );
    modport slave (
        input  in_valid, opcode, A, B, cin, serial_in, direction, shamt,
               red_op_A, red_op_B, bypass_A, bypass_B,
        output in_ready, out_valid, out, err, leds
    );
endinterface

// File: rtl/alsu_seq_mult.sv
// Iterative shift-add multiplier: one partial product per clock, BITS clocks per product.
module alsu_seq_mult #(
    parameter int BITS = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    input  logic [BITS-1:0]     i_a,
    input  logic [BITS-1:0]     i_b,
    output logic                o_done,
    output logic [2*BITS-1:0]   o_product
);
    localparam int CW = $clog2(BITS+1);

    logic                r_busy;
    logic [2*BITS-1:0]   r_mcand;
    logic [BITS-1:0]     r_mplier;
    logic [2*BITS-1:0]   r_acc;
    logic [CW-1:0]       r_cnt;
    logic [2*BITS-1:0]   w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Product is presented combinationally on the final step so the owner can register it that edge.
    assign o_done    = r_busy & (r_cnt == CW'(BITS-1));
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_mcand  <= {{BITS{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (o_done) r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alsu_pipe.sv
// ALSU with valid/ready input, registered result strobe, iterative multiply,
// shift/rotate on the result register and an LED blinker for invalid commands.
module alsu_pipe import alsu_pkg::*; #(
    parameter int    BITS           = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    alsu_pipe_if.slave  bus
);
    localparam int W  = 2*BITS;
    localparam int BW = $clog2(BLINK_DIV+1);
    // Anything other than "B" falls back to A-priority.
    localparam bit PICK_A  = (INPUT_PRIORITY == PRI_A) || (INPUT_PRIORITY != PRI_B);
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_err;
    logic [W-1:0]    r_out;
    logic [15:0]     r_leds;
    logic [BW-1:0]   r_blink_cnt;

    logic            w_accept, w_invalid, w_bypass, w_mul_start, w_mul_done;
    logic [W-1:0]    w_prod, w_byp, w_alu, w_shift, w_rot, w_fill;
    logic [BITS-1:0] w_red_src;
    logic [2*W-1:0]  w_dbl;
    logic [31:0]     w_rot_amt;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_invalid   = is_invalid(bus.opcode, bus.red_op_A, bus.red_op_B);
    assign w_bypass    = bus.bypass_A | bus.bypass_B;
    assign w_mul_start = w_accept & ~w_invalid & ~w_bypass & (bus.opcode == OP_MUL);
    assign w_byp       = {{BITS{1'b0}}, (bus.bypass_A & (~bus.bypass_B | PICK_A)) ? bus.A : bus.B};
    assign w_red_src   = (bus.red_op_A & (~bus.red_op_B | PICK_A)) ? bus.A : bus.B;

    alsu_seq_mult #(.BITS(BITS)) u_mult (
        .clk       (clk),
        .rstn      (rstn),
        .i_start   (w_mul_start),
        .i_a       (bus.A),
        .i_b       (bus.B),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    // Shift/rotate act on the held result, not on the operands.
    always_comb begin
        w_fill = {W{bus.serial_in}};
        if (32'(bus.shamt) >= 32'(W))
            w_shift = w_fill;
        else if (bus.direction)
            w_shift = (r_out << bus.shamt) | (w_fill & ~({W{1'b1}} << bus.shamt));
        else
            w_shift = (r_out >> bus.shamt) | (w_fill & ~({W{1'b1}} >> bus.shamt));
    end

    // Rotate left by r equals the low half of {out,out} shifted right by W-r.
    assign w_rot_amt = 32'(bus.shamt) % 32'(W);
    assign w_dbl     = {r_out, r_out};
    assign w_rot     = W'(w_dbl >> (bus.direction ? (32'(W) - w_rot_amt) : w_rot_amt));

    always_comb begin
        w_alu = '0;
        case (bus.opcode)
            OP_AND:   w_alu = (bus.red_op_A | bus.red_op_B) ? W'(&w_red_src)
                                                            : {{BITS{1'b0}}, bus.A & bus.B};
            OP_XOR:   w_alu = (bus.red_op_A | bus.red_op_B) ? W'(^w_red_src)
                                                            : {{BITS{1'b0}}, bus.A ^ bus.B};
            OP_ADD:   w_alu = W'(bus.A) + W'(bus.B) + W'(ADD_CIN & bus.cin);
            OP_SHIFT: w_alu = w_shift;
            OP_ROT:   w_alu = w_rot;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_out       <= '0;
            r_leds      <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == ST_BUSY) begin
                if (w_mul_done) begin
                    r_out       <= w_prod;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                end
            end else if (w_accept) begin
                r_blink_cnt <= '0;
                if (w_invalid) begin
                    r_out       <= '0;
                    r_out_valid <= 1'b1;
                    r_err       <= 1'b1;
                    r_leds      <= 16'hFFFF;
                end else begin
                    r_err  <= 1'b0;
                    r_leds <= '0;
                    if (w_bypass) begin
                        r_out       <= w_byp;
                        r_out_valid <= 1'b1;
                    end else if (bus.opcode == OP_MUL) begin
                        r_state    <= ST_BUSY;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_out       <= w_alu;
                        r_out_valid <= 1'b1;
                    end
                end
            end else if (r_err) begin
                if (r_blink_cnt == BW'(BLINK_DIV-1)) begin
                    r_blink_cnt <= '0;
                    r_leds      <= ~r_leds;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.err       = r_err;
    assign bus.leds      = r_leds;
endmodule
